// File: rtl/dct_sample_loader.sv
// rtl/dct_sample_loader.sv - collects 8 samples into a staging buffer and hands each full block to the DCT stages
// Load side fills staging slots; run side times the compute window that the parallel block a0..a7 feeds.
module dct_sample_loader #(
   parameter int CALC_CYCLES = 12,
   parameter int DW          = 24
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          in_ready,
   output logic [DW-1:0] a0,
   output logic [DW-1:0] a1,
   output logic [DW-1:0] a2,
   output logic [DW-1:0] a3,
   output logic [DW-1:0] a4,
   output logic [DW-1:0] a5,
   output logic [DW-1:0] a6,
   output logic [DW-1:0] a7,
   output logic [3:0]    cnt_clk,
   output logic          blk_start,
   output logic          busy
);

   typedef enum logic {COLLECT, FULL} load_t;
   typedef enum logic {IDLE, RUN} run_t;

   localparam logic [3:0] LAST_PHASE = 4'(CALC_CYCLES - 1);
   localparam logic [3:0] IDLE_PHASE = 4'hF;

   load_t         load_st;
   run_t          run_st;
   logic [2:0]    idx;
   logic [DW-1:0] stage [8];
   logic [DW-1:0] blk   [8];
   logic          accept;
   logic          handover;

   // in_ready decodes registered state only; rst gates it so no sample is taken while resetting
   assign in_ready = (load_st == COLLECT) && !rst;
   assign accept   = in_valid && in_ready;
   assign handover = (load_st == FULL) &&
                     ((run_st == IDLE) || (cnt_clk == LAST_PHASE));

   always_ff @(posedge clk) begin
      if (rst) begin
         load_st   <= COLLECT;
         run_st    <= IDLE;
         idx       <= 3'd0;
         cnt_clk   <= IDLE_PHASE;
         blk_start <= 1'b0;
         busy      <= 1'b0;
         for (int i = 0; i < 8; i++) begin
            stage[i] <= '0;
            blk[i]   <= '0;
         end
      end else begin
         if (accept) begin
            stage[idx] <= in_data;
            idx        <= idx + 3'd1;
            if (idx == 3'd7)
               load_st <= FULL;
         end

         // handover only fires while FULL, so it never coincides with an accept
         if (handover) begin
            for (int i = 0; i < 8; i++)
               blk[i] <= stage[i];
            load_st   <= COLLECT;
            run_st    <= RUN;
            cnt_clk   <= 4'd0;
            blk_start <= 1'b1;
            busy      <= 1'b1;
         end else if (run_st == RUN) begin
            blk_start <= 1'b0;
            if (cnt_clk == LAST_PHASE) begin
               run_st  <= IDLE;
               cnt_clk <= IDLE_PHASE;
               busy    <= 1'b0;
            end else begin
               cnt_clk <= cnt_clk + 4'd1;
            end
         end
      end
   end

   assign a0 = blk[0];
   assign a1 = blk[1];
   assign a2 = blk[2];
   assign a3 = blk[3];
   assign a4 = blk[4];
   assign a5 = blk[5];
   assign a6 = blk[6];
   assign a7 = blk[7];

endmodule

// File: tb/tb_dct_sample_loader.sv
// tb/tb_dct_sample_loader.sv - directed self-checking bench for dct_sample_loader
// Instance m uses default CALC_CYCLES=12; instance s uses CALC_CYCLES=3.
module tb_dct_sample_loader;

   logic        clk = 1'b0;
   logic        rst, in_valid, rst_s, in_valid_s;
   logic [23:0] in_data, in_data_s;
   logic        in_ready, in_ready_s;
   logic [23:0] am [8];
   logic [23:0] as [8];
   logic [3:0]  cnt_clk, cnt_clk_s;
   logic        blk_start, blk_start_s, busy, busy_s;

   int checks = 0;
   int errors = 0;
   logic [23:0] exp_blk [8];

   always #5 clk = ~clk;

   dct_sample_loader dut_m (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .a0(am[0]), .a1(am[1]), .a2(am[2]), .a3(am[3]),
      .a4(am[4]), .a5(am[5]), .a6(am[6]), .a7(am[7]),
      .cnt_clk(cnt_clk), .blk_start(blk_start), .busy(busy)
   );

   dct_sample_loader #(.CALC_CYCLES(3), .DW(24)) dut_s (
      .clk(clk), .rst(rst_s), .in_valid(in_valid_s), .in_data(in_data_s), .in_ready(in_ready_s),
      .a0(as[0]), .a1(as[1]), .a2(as[2]), .a3(as[3]),
      .a4(as[4]), .a5(as[5]), .a6(as[6]), .a7(as[7]),
      .cnt_clk(cnt_clk_s), .blk_start(blk_start_s), .busy(busy_s)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic chk_m(input string tag);
      for (int i = 0; i < 8; i++) chk($sformatf("%s_a%0d", tag, i), {8'h0, am[i]}, {8'h0, exp_blk[i]});
   endtask

   task automatic chk_s(input string tag);
      for (int i = 0; i < 8; i++) chk($sformatf("%s_a%0d", tag, i), {8'h0, as[i]}, {8'h0, exp_blk[i]});
   endtask

   task automatic set_seq(input logic [23:0] base);
      for (int i = 0; i < 8; i++) exp_blk[i] = base + 24'(i);
   endtask

   initial begin
      logic [23:0] tog [8];
      tog[0] = 24'hFFFFFF; tog[1] = 24'h800000; tog[2] = 24'h7FFFFF; tog[3] = 24'h000001;
      tog[4] = 24'hFFFFFE; tog[5] = 24'h123456; tog[6] = 24'hABCDEF; tog[7] = 24'h000000;

      rst = 1'b1; in_valid = 1'b0; in_data = '0;
      rst_s = 1'b1; in_valid_s = 1'b0; in_data_s = '0;
      tick(); tick();

      // reset state
      chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
      chk("rst_cnt", {28'b0, cnt_clk}, 32'hF);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_blk_start", {31'b0, blk_start}, 32'd0);
      set_seq(24'd0);
      for (int i = 0; i < 8; i++) exp_blk[i] = 24'd0;
      chk_m("rst");
      rst = 1'b0; rst_s = 1'b0;
      #1;
      chk("rel_in_ready", {31'b0, in_ready}, 32'd1);

      // basic block 1..8, full window
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; in_data = 24'(i + 1);
         tick();
      end
      in_valid = 1'b0;
      chk("full_in_ready", {31'b0, in_ready}, 32'd0);
      chk("full_cnt", {28'b0, cnt_clk}, 32'hF);
      tick();
      set_seq(24'd1);
      chk_m("b1");
      chk("b1_in_ready", {31'b0, in_ready}, 32'd1);
      chk("b1_busy", {31'b0, busy}, 32'd1);
      chk("b1_cnt0", {28'b0, cnt_clk}, 32'd0);
      chk("b1_start0", {31'b0, blk_start}, 32'd1);
      for (int k = 1; k < 12; k++) begin
         tick();
         chk($sformatf("b1_cnt%0d", k), {28'b0, cnt_clk}, 32'(k));
         chk($sformatf("b1_start%0d", k), {31'b0, blk_start}, 32'd0);
      end
      tick();
      chk("b1_end_cnt", {28'b0, cnt_clk}, 32'hF);
      chk("b1_end_busy", {31'b0, busy}, 32'd0);
      chk_m("b1_hold");

      // continuous 16 samples, back-to-back windows
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; in_data = 24'(i + 1);
         tick();
      end
      in_data = 24'd9;
      tick();
      chk("c1_cnt", {28'b0, cnt_clk}, 32'd0);
      chk("c1_in_ready", {31'b0, in_ready}, 32'd1);
      for (int i = 0; i < 8; i++) begin
         in_data = 24'(i + 9);
         tick();
      end
      in_data = 24'd17;
      chk("c2_full_cnt", {28'b0, cnt_clk}, 32'd8);
      chk("c2_full_in_ready", {31'b0, in_ready}, 32'd0);
      tick(); tick(); tick();
      chk("c2_cnt11", {28'b0, cnt_clk}, 32'd11);
      chk("c2_in_ready11", {31'b0, in_ready}, 32'd0);
      set_seq(24'd1);
      chk_m("c1_hold");
      tick();
      in_valid = 1'b0;
      chk("c2_cnt0", {28'b0, cnt_clk}, 32'd0);
      chk("c2_start", {31'b0, blk_start}, 32'd1);
      set_seq(24'd9);
      chk_m("c2");
      for (int k = 0; k < 12; k++) tick();
      chk("c2_idle", {28'b0, cnt_clk}, 32'hF);

      // toggling valid with signed extremes
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; in_data = tog[i];
         tick();
         in_valid = 1'b0; in_data = 24'hDEADBE;
         tick();
      end
      for (int i = 0; i < 8; i++) exp_blk[i] = tog[i];
      chk_m("tog");
      chk("tog_cnt", {28'b0, cnt_clk}, 32'd0);
      for (int k = 0; k < 12; k++) tick();

      // reset mid-block discards partial content
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_data = 24'hAA0000 + 24'(i);
         tick();
      end
      in_valid = 1'b0; rst = 1'b1;
      tick();
      for (int i = 0; i < 8; i++) exp_blk[i] = 24'd0;
      chk_m("mid_rst");
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; in_data = 24'h10 + 24'(i);
         tick();
      end
      in_valid = 1'b0;
      tick();
      set_seq(24'h10);
      chk_m("after_rst");

      // reset mid-window
      for (int k = 0; k < 6; k++) tick();
      chk("win_cnt6", {28'b0, cnt_clk}, 32'd6);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("win_rst_cnt", {28'b0, cnt_clk}, 32'hF);
      chk("win_rst_busy", {31'b0, busy}, 32'd0);
      chk("win_rst_a0", {8'h0, am[0]}, 32'd0);
      chk("win_rst_a7", {8'h0, am[7]}, 32'd0);

      // CALC_CYCLES=3 instance, continuous input
      in_valid_s = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_data_s = 24'(i + 1);
         tick();
      end
      in_data_s = 24'd9;
      tick();
      set_seq(24'd1);
      chk_s("s1");
      chk("s_cnt0", {28'b0, cnt_clk_s}, 32'd0);
      for (int i = 0; i < 8; i++) begin
         in_data_s = 24'(i + 9);
         tick();
         if (i == 0) chk("s_cnt1", {28'b0, cnt_clk_s}, 32'd1);
         if (i == 1) chk("s_cnt2", {28'b0, cnt_clk_s}, 32'd2);
         if (i == 2) chk("s_cntF", {28'b0, cnt_clk_s}, 32'hF);
         if (i == 2) chk("s_busy0", {31'b0, busy_s}, 32'd0);
      end
      in_data_s = 24'd17;
      chk("s_wait_cnt", {28'b0, cnt_clk_s}, 32'hF);
      chk_s("s1_hold");
      tick();
      in_valid_s = 1'b0;
      chk("s2_cnt0", {28'b0, cnt_clk_s}, 32'd0);
      set_seq(24'd9);
      chk_s("s2");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dct_sample_loader.md
DCT_SAMPLE_LOADER -- requirements
Module: dct_sample_loader

Interface
REQ-001 Parameter CALC_CYCLES, default 12, is the length of one compute window in cycles; legal range 3..15.
REQ-002 Parameter DW, default 24, is the sample and output word width.
REQ-003 clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  is a synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 in_valid  input  1  means in_data holds a sample.
REQ-006 in_data  input  DW  is a two's-complement sample.
REQ-007 in_ready  output  1  means the block accepts a sample this cycle; a transfer occurs when in_valid and in_ready are both 1.
REQ-008 a0..a7  output  DW each  are the registered parallel block feeding the DCT stages.
REQ-009 cnt_clk  output  4  is the phase counter broadcast to the DCT stages.
REQ-010 blk_start  output  1  is high for exactly the cycles in which cnt_clk is 0.
REQ-011 busy  output  1  is high while a compute window is running.

Function
REQ-012 Load side FSM states: COLLECT (in_ready=1) and FULL (in_ready=0).
REQ-013 In COLLECT, the k-th accepted sample of a block (k=0..7) goes into staging slot k; a 3-bit index increments per accepted sample and wraps 7->0.
REQ-014 Accepting slot 7 moves COLLECT->FULL on that edge.
REQ-015 Run side FSM states: IDLE (cnt_clk=4'hF, busy=0) and RUN (cnt_clk=0..CALC_CYCLES-1, busy=1).
REQ-016 A hand-over fires on a cycle where load side is FULL and run side is either IDLE or in RUN with cnt_clk==CALC_CYCLES-1.
REQ-017 On the hand-over edge: a0..a7 <= staging slots 0..7, cnt_clk <= 0, run side enters or stays in RUN, load side returns to COLLECT.
REQ-018 In RUN without a hand-over: cnt_clk increments by 1 per cycle; at CALC_CYCLES-1 the next edge sets cnt_clk=4'hF and IDLE.
REQ-019 a0..a7 stay constant for the whole compute window and change only on a hand-over edge.
REQ-020 Latency: 8th sample accepted at edge E with run side idle -> FULL after E, hand-over at E+1, cnt_clk=0 and new a0..a7 visible after E+1.
REQ-021 Back-to-back: when a block is FULL before the last window cycle, cnt_clk goes CALC_CYCLES-1 -> 0 with no idle cycle.
REQ-022 While FULL, in_ready=0 and in_data/in_valid are ignored; samples are never dropped or overwritten.
REQ-023 The staging buffer may fill during RUN, so loading the next block overlaps the current window.
REQ-024 in_ready is a registered state decode with no combinational path from in_valid.
REQ-025 No arithmetic on sample data; words pass through bit-exact, width DW.
REQ-026 cnt_clk value 4'hF never occurs inside a window, so downstream stages with CNT_CLK+2 < CALC_CYCLES see no spurious phase while idle.

Reset
REQ-027 While rst=1 at an edge: load side COLLECT, index 0, run side IDLE, cnt_clk=4'hF, a0..a7=0, staging=0, blk_start=0, busy=0.
REQ-028 in_ready is 0 during a cycle where rst=1 and is 1 in the first cycle after reset is released.
REQ-029 Reset mid-block discards the partial staging content, and reset mid-window aborts the window; after release the next accepted sample goes to slot 0.

Verification
REQ-030 Reset, then 8 samples 1..8 on consecutive cycles -> a0..a7=1..8 one cycle after FULL; cnt_clk 0..11 then F; blk_start high only at cnt_clk=0.
REQ-031 Continuous in_valid with 16 samples 0x000001..0x000010 -> in_ready low from 8th accept until hand-over; 2nd block a0..a7=9..16 loaded on the edge where cnt_clk goes 11->0; no sample lost.
REQ-032 in_valid toggling 1,0,1,0 with samples 0xFFFFFF, 0x800000, 0x7FFFFF, ... -> slot order follows accepted samples only; values reach a0..a7 unchanged, with negatives intact.
REQ-033 rst asserted after 5 samples, then 8 samples 0x10..0x17 -> a0..a7=0x10..0x17; no earlier samples appear.
REQ-034 rst asserted at cnt_clk=6 -> cnt_clk=F and busy=0 the next cycle; a0..a7=0.
REQ-035 CALC_CYCLES=3, continuous input -> cnt_clk runs 0,1,2,F; the window waits on loading; a0..a7 change only on hand-over edges.
